// File: rtl/rle_encoder_pkg.sv
// Shared types, constants and coefficient helpers for the JPEG run-length/DPCM encoder.
// Optional symbol statistics are enabled with the RLE_STATS_EN macro (see rle_encoder).
package rle_encoder_pkg;

    localparam int COEF_WIDTH = 12;
    localparam int BLOCK_LEN  = 64;

    localparam logic [3:0] ZRL_RUN = 4'd15;
    localparam logic [3:0] EOB_RUN = 4'd0;

    typedef struct packed {
        logic                  dc;
        logic [3:0]            run;
        logic [3:0]            size;
        logic [COEF_WIDTH-1:0] amp;
        logic                  sop;
        logic                  eop;
    } rleSym_t;

    typedef struct packed {
        logic [1:0] zrl_pend;
        rleSym_t    sym;
    } rleEntry_t;

    function automatic logic [3:0] coefSize(input logic signed [COEF_WIDTH-1:0] v);
        logic [COEF_WIDTH-1:0] mag;
        logic [3:0]            s;
        // |-2^(W-1)| still fits as an unsigned W-bit magnitude
        mag = v[COEF_WIDTH-1] ? (~v + COEF_WIDTH'(1)) : v;
        s   = 4'd0;
        for (int i = 0; i < COEF_WIDTH; i++) begin
            if (mag[i]) s = 4'(i + 1);
        end
        return s;
    endfunction

    function automatic logic [COEF_WIDTH-1:0] coefAmp(input logic signed [COEF_WIDTH-1:0] v,
                                                      input logic [3:0] size);
        logic [COEF_WIDTH-1:0] raw;
        logic [COEF_WIDTH-1:0] amp;
        raw = v[COEF_WIDTH-1] ? (v - COEF_WIDTH'(1)) : v;
        for (int i = 0; i < COEF_WIDTH; i++) begin
            amp[i] = (i < int'(size)) ? raw[i] : 1'b0;
        end
        return amp;
    endfunction

endpackage

// File: rtl/rle_encoder_if.sv
// Coefficient input and symbol output bundle of the RLE encoder.
// The encoder sits on the slave modport; the coefficient source / symbol sink on master.
interface rle_encoder_if;
    import rle_encoder_pkg::*;

    logic                  in_valid;
    logic [COEF_WIDTH-1:0] in_data;
    logic                  in_sop;
    logic                  in_eop;

    logic                  sym_valid;
    logic                  sym_ready;
    logic                  sym_dc;
    logic [3:0]            sym_run;
    logic [3:0]            sym_size;
    logic [COEF_WIDTH-1:0] sym_amp;
    logic                  sym_sop;
    logic                  sym_eop;

    modport master (
        output in_valid, in_data, in_sop, in_eop, sym_ready,
        input  sym_valid, sym_dc, sym_run, sym_size, sym_amp, sym_sop, sym_eop
    );

    modport slave (
        input  in_valid, in_data, in_sop, in_eop, sym_ready,
        output sym_valid, sym_dc, sym_run, sym_size, sym_amp, sym_sop, sym_eop
    );
endinterface

// File: rtl/rle_encoder_sym_fifo.sv
// Show-ahead synchronous FIFO of encoder entries; a write while full is accepted only
// when a read frees a slot in the same cycle.
module rle_encoder_sym_fifo
    import rle_encoder_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      wr_en_i,
    input  rleEntry_t wr_data_i,
    input  logic      rd_en_i,
    output rleEntry_t rd_data_o,
    output logic      full_o,
    output logic      empty_o
);
    localparam int AW = $clog2(DEPTH);

    rleEntry_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_wr;
    logic          do_rd;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign do_rd     = rd_en_i && !empty_o;
    assign do_wr     = wr_en_i && (!full_o || do_rd);
    assign rd_data_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end
endmodule

// File: rtl/rle_encoder.sv
// JPEG run-length/DPCM encoder: zigzag coefficients in, (run,size,amp) symbols out via a FIFO.
// Define RLE_STATS_EN to add the stat_symbols per-frame symbol counter port.
module rle_encoder
    import rle_encoder_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    rle_encoder_if.slave  bus,
    output logic          err_overflow
`ifdef RLE_STATS_EN
    ,
    output logic [15:0]   stat_symbols
`endif
);
    localparam logic [5:0] LAST_IDX = 6'(BLOCK_LEN - 1);

    logic [5:0]                   idx_q,  idx_d;
    logic [3:0]                   run_q,  run_d;
    logic [1:0]                   zrl_q,  zrl_d;
    logic signed [COEF_WIDTH-1:0] pred_q, pred_d;
    logic                         wr_q,   wr_d;
    rleEntry_t                    ent_q,  ent_d;
    logic                         err_q;
    logic [1:0]                   zcnt_q;

    logic [5:0]                   cur_idx;
    logic signed [COEF_WIDTH-1:0] coef;
    logic signed [COEF_WIDTH-1:0] pred_eff;
    logic signed [COEF_WIDTH:0]   diff;
    logic signed [COEF_WIDTH-1:0] diff_sat;
    logic [3:0]                   sz_dc;
    logic [3:0]                   sz_ac;
    logic [4:0]                   run_inc;

    assign coef     = bus.in_data;
    assign cur_idx  = bus.in_sop ? 6'd0 : idx_q;
    assign pred_eff = bus.in_sop ? '0 : pred_q;
    assign diff     = {coef[COEF_WIDTH-1], coef} - {pred_eff[COEF_WIDTH-1], pred_eff};
    assign sz_dc    = coefSize(diff_sat);
    assign sz_ac    = coefSize(coef);
    assign run_inc  = {1'b0, run_q} + 5'd1;

    always_comb begin
        if (diff[COEF_WIDTH] != diff[COEF_WIDTH-1]) begin
            diff_sat = diff[COEF_WIDTH] ? {1'b1, {(COEF_WIDTH-1){1'b0}}}
                                        : {1'b0, {(COEF_WIDTH-1){1'b1}}};
        end else begin
            diff_sat = diff[COEF_WIDTH-1:0];
        end
    end

    always_comb begin
        wr_d   = 1'b0;
        ent_d  = '0;
        run_d  = run_q;
        zrl_d  = zrl_q;
        pred_d = pred_q;
        idx_d  = idx_q;
        if (bus.in_valid) begin
            idx_d = cur_idx + 6'd1;
            if (cur_idx == 6'd0) begin
                wr_d           = 1'b1;
                ent_d.sym.dc   = 1'b1;
                ent_d.sym.size = sz_dc;
                ent_d.sym.amp  = coefAmp(diff_sat, sz_dc);
                ent_d.sym.sop  = bus.in_sop;
                pred_d         = coef;
                run_d          = 4'd0;
                zrl_d          = 2'd0;
            end else if (coef == '0) begin
                if (run_inc == 5'd16) begin
                    run_d = 4'd0;
                    zrl_d = zrl_q + 2'd1;
                end else begin
                    run_d = run_inc[3:0];
                end
                // a trailing zero always leaves a run or ZRL pending, so the block ends in EOB
                if (cur_idx == LAST_IDX) begin
                    wr_d          = 1'b1;
                    ent_d.sym.run = EOB_RUN;
                    ent_d.sym.eop = bus.in_eop;
                end
            end else begin
                wr_d           = 1'b1;
                ent_d.zrl_pend = zrl_q;
                ent_d.sym.run  = run_q;
                ent_d.sym.size = sz_ac;
                ent_d.sym.amp  = coefAmp(coef, sz_ac);
                ent_d.sym.eop  = (cur_idx == LAST_IDX) && bus.in_eop;
                run_d          = 4'd0;
                zrl_d          = 2'd0;
            end
            if (cur_idx == LAST_IDX) begin
                run_d = 4'd0;
                zrl_d = 2'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            run_q  <= '0;
            zrl_q  <= '0;
            pred_q <= '0;
            wr_q   <= 1'b0;
            ent_q  <= '0;
        end else begin
            idx_q  <= idx_d;
            run_q  <= run_d;
            zrl_q  <= zrl_d;
            pred_q <= pred_d;
            wr_q   <= wr_d;
            ent_q  <= ent_d;
        end
    end

    rleEntry_t head;
    rleSym_t   sym_out;
    logic      fifo_full;
    logic      fifo_empty;
    logic      emit_zrl;
    logic      accept;
    logic      pop;

    rle_encoder_sym_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_q),
        .wr_data_i (ent_q),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // pending ZRLs of the head entry go out first; the entry pops with its own symbol
    assign emit_zrl      = (head.zrl_pend > zcnt_q);
    assign bus.sym_valid = !fifo_empty;
    assign accept        = bus.sym_valid && bus.sym_ready;
    assign pop           = accept && !emit_zrl;

    always_comb begin
        sym_out = '0;
        if (!fifo_empty) begin
            if (emit_zrl) sym_out.run = ZRL_RUN;
            else          sym_out     = head.sym;
        end
    end

    assign bus.sym_dc   = sym_out.dc;
    assign bus.sym_run  = sym_out.run;
    assign bus.sym_size = sym_out.size;
    assign bus.sym_amp  = sym_out.amp;
    assign bus.sym_sop  = sym_out.sop;
    assign bus.sym_eop  = sym_out.eop;
    assign err_overflow = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (pop)         zcnt_q <= 2'd0;
            else if (accept) zcnt_q <= zcnt_q + 2'd1;
            if (wr_q && fifo_full && !pop) err_q <= 1'b1;
        end
    end

`ifdef RLE_STATS_EN
    logic [15:0] cnt_q;
    logic [15:0] stat_q;
    logic [15:0] cnt_next;

    always_comb begin
        cnt_next = cnt_q;
        if (sym_out.sop)           cnt_next = 16'd1;
        else if (cnt_q != 16'hFFFF) cnt_next = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            stat_q <= '0;
        end else if (accept) begin
            cnt_q <= cnt_next;
            if (sym_out.eop) stat_q <= cnt_next;
        end
    end

    assign stat_symbols = stat_q;
`endif
endmodule
